multicycle_control: RTL and testbench

Main control FSM for the multi-cycle RISC-V datapath. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives the 3-bit `ALU_Op_o` class code consumed by `ALU_Control` (together with funct7/funct3) and handshakes with a shared instruction/data memory through a ready signal. It replaces the purely combinational main control of the single-cycle core.

---
 rtl/multicycle_control.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RISC-V core: fetch, decode, execute, memory, write-back.
// Latency: 3 cycles (branch/JAL), 4 (R/I/LUI/store), 5 (load), plus one per memory wait cycle.
// Backpressure: FETCH, MEM_RD and MEM_WR hold their request until mem_ready_i; reset forces Mealy strobes low.
//
// Ports:
//   clk, reset (async, active-low)      clock and reset
//   opcode_i, mem_ready_i, branch_taken_i instruction opcode, memory completion, branch condition
//   ALU_Op_o, ALU_Src_o                  ALU class code and operand-B select
//   IorD_o, Mem_Read_o, Mem_Write_o      memory address source and requests
//   IR_Write_o, PC_Write_o, PC_Src_o     instruction register / PC update controls
//   Reg_Write_o, Mem_to_Reg_o            register-file write enable and write-back source
//   instr_done_o, illegal_o, state_o     retirement pulse, trap flag, debug state
module multicycle_control #(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode_i,
   input  logic       mem_ready_i,
   input  logic       branch_taken_i,
   output logic [2:0] ALU_Op_o,
   output logic       ALU_Src_o,
   output logic       IorD_o,
   output logic       Mem_Read_o,
   output logic       Mem_Write_o,
   output logic       IR_Write_o,
   output logic       PC_Write_o,
   output logic [1:0] PC_Src_o,
   output logic       Reg_Write_o,
   output logic [1:0] Mem_to_Reg_o,
   output logic       instr_done_o,
   output logic       illegal_o,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_EXEC_LUI = 4'd4,
      S_EXEC_B   = 4'd5,
      S_EXEC_JAL = 4'd6,
      S_MEM_ADDR = 4'd7,
      S_MEM_RD   = 4'd8,
      S_MEM_WR   = 4'd9,
      S_WB_ALU   = 4'd10,
      S_WB_MEM   = 4'd11,
      S_TRAP     = 4'd12
   } state_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [2:0] CLS_R    = 3'b000;
   localparam logic [2:0] CLS_I    = 3'b001;
   localparam logic [2:0] CLS_LUI  = 3'b010;
   localparam logic [2:0] CLS_B    = 3'b011;
   localparam logic [2:0] CLS_S    = 3'b100;
   localparam logic [2:0] CLS_LOAD = 3'b101;
   localparam logic [2:0] CLS_JAL  = 3'b111;

   state_t     r_state;
   logic [2:0] r_alu_op;
   logic       r_is_store;

   // Mealy strobes before reset gating
   logic       w_ir_write;
   logic       w_pc_write;
   logic       w_instr_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= state_t'(RESET_STATE);
         r_alu_op   <= CLS_R;
         r_is_store <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (mem_ready_i) r_state <= S_DECODE;
            end
            S_DECODE: begin
               r_is_store <= (opcode_i == OP_STORE);
               case (opcode_i)
                  OP_R:     begin r_alu_op <= CLS_R;    r_state <= S_EXEC_R;   end
                  OP_I:     begin r_alu_op <= CLS_I;    r_state <= S_EXEC_I;   end
                  OP_LUI:   begin r_alu_op <= CLS_LUI;  r_state <= S_EXEC_LUI; end
                  OP_B:     begin r_alu_op <= CLS_B;    r_state <= S_EXEC_B;   end
                  OP_STORE: begin r_alu_op <= CLS_S;    r_state <= S_MEM_ADDR; end
                  OP_LOAD:  begin r_alu_op <= CLS_LOAD; r_state <= S_MEM_ADDR; end
                  OP_JAL:   begin r_alu_op <= CLS_JAL;  r_state <= S_EXEC_JAL; end
                  default:  begin r_alu_op <= CLS_R;    r_state <= S_TRAP;     end
               endcase
            end
            S_EXEC_R, S_EXEC_I, S_EXEC_LUI: r_state <= S_WB_ALU;
            S_EXEC_B, S_EXEC_JAL:           r_state <= S_FETCH;
            S_MEM_ADDR: r_state <= r_is_store ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
               if (mem_ready_i) r_state <= S_WB_MEM;
            end
            S_MEM_WR: begin
               if (mem_ready_i) r_state <= S_FETCH;
            end
            S_WB_ALU, S_WB_MEM: r_state <= S_FETCH;
            S_TRAP:   r_state <= S_TRAP;
            default:  r_state <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      ALU_Op_o     = 3'b000;
      ALU_Src_o    = 1'b0;
      IorD_o       = 1'b0;
      Mem_Read_o   = 1'b0;
      Mem_Write_o  = 1'b0;
      PC_Src_o     = 2'b00;
      Reg_Write_o  = 1'b0;
      Mem_to_Reg_o = 2'b00;
      illegal_o    = 1'b0;
      w_ir_write   = 1'b0;
      w_pc_write   = 1'b0;
      w_instr_done = 1'b0;
      case (r_state)
         S_FETCH: begin
            Mem_Read_o = 1'b1;
            w_ir_write = mem_ready_i;
            w_pc_write = mem_ready_i;
         end
         S_DECODE: ;
         S_EXEC_R: begin
            ALU_Op_o = r_alu_op;
         end
         S_EXEC_I, S_EXEC_LUI, S_MEM_ADDR: begin
            ALU_Op_o  = r_alu_op;
            ALU_Src_o = 1'b1;
         end
         S_EXEC_B: begin
            ALU_Op_o     = r_alu_op;
            PC_Src_o     = 2'b01;
            w_pc_write   = branch_taken_i;
            w_instr_done = 1'b1;
         end
         S_EXEC_JAL: begin
            ALU_Op_o     = r_alu_op;
            Reg_Write_o  = 1'b1;
            Mem_to_Reg_o = 2'b10;
            PC_Src_o     = 2'b10;
            w_pc_write   = 1'b1;
            w_instr_done = 1'b1;
         end
         S_MEM_RD: begin
            ALU_Op_o   = r_alu_op;
            ALU_Src_o  = 1'b1;
            IorD_o     = 1'b1;
            Mem_Read_o = 1'b1;
         end
         S_MEM_WR: begin
            ALU_Op_o     = r_alu_op;
            ALU_Src_o    = 1'b1;
            IorD_o       = 1'b1;
            Mem_Write_o  = 1'b1;
            w_instr_done = mem_ready_i;
         end
         S_WB_ALU: begin
            ALU_Op_o     = r_alu_op;
            // Only the R class uses rs2; I-ALU and LUI keep the immediate selected.
            ALU_Src_o    = (r_alu_op != CLS_R);
            Reg_Write_o  = 1'b1;
            w_instr_done = 1'b1;
         end
         S_WB_MEM: begin
            ALU_Op_o     = r_alu_op;
            Reg_Write_o  = 1'b1;
            Mem_to_Reg_o = 2'b01;
            w_instr_done = 1'b1;
         end
         S_TRAP: begin
            illegal_o = 1'b1;
         end
         default: ;
      endcase
   end

   // The reset pin gates the strobes directly so nothing commits while reset is held low.
   assign IR_Write_o   = w_ir_write & reset;
   assign PC_Write_o   = w_pc_write & reset;
   assign instr_done_o = w_instr_done & reset;
   assign state_o      = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control.
// Per-cycle stimulus and expected output vectors are queued together and compared at the falling edge.
// Covers reset, every instruction class, memory wait states, trap and reset mid-store.
module tb_multicycle_control;

   logic       clk;
   logic       reset;
   logic [6:0] opcode_i;
   logic       mem_ready_i;
   logic       branch_taken_i;
   logic [2:0] ALU_Op_o;
   logic       ALU_Src_o;
   logic       IorD_o;
   logic       Mem_Read_o;
   logic       Mem_Write_o;
   logic       IR_Write_o;
   logic       PC_Write_o;
   logic [1:0] PC_Src_o;
   logic       Reg_Write_o;
   logic [1:0] Mem_to_Reg_o;
   logic       instr_done_o;
   logic       illegal_o;
   logic [3:0] state_o;

   int checks   = 0;
   int failures = 0;

   logic [8:0]  stim[$];   // {opcode, mem_ready, branch_taken}
   logic [19:0] sb[$];     // expected output vector per cycle

   multicycle_control dut (
      .clk            (clk),
      .reset          (reset),
      .opcode_i       (opcode_i),
      .mem_ready_i    (mem_ready_i),
      .branch_taken_i (branch_taken_i),
      .ALU_Op_o       (ALU_Op_o),
      .ALU_Src_o      (ALU_Src_o),
      .IorD_o         (IorD_o),
      .Mem_Read_o     (Mem_Read_o),
      .Mem_Write_o    (Mem_Write_o),
      .IR_Write_o     (IR_Write_o),
      .PC_Write_o     (PC_Write_o),
      .PC_Src_o       (PC_Src_o),
      .Reg_Write_o    (Reg_Write_o),
      .Mem_to_Reg_o   (Mem_to_Reg_o),
      .instr_done_o   (instr_done_o),
      .illegal_o      (illegal_o),
      .state_o        (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [19:0] obs();
      return {state_o, ALU_Op_o, ALU_Src_o, IorD_o, Mem_Read_o, Mem_Write_o, IR_Write_o,
              PC_Write_o, PC_Src_o, Reg_Write_o, Mem_to_Reg_o, instr_done_o, illegal_o};
   endfunction

   // Field order: state, alu_op, alu_src, iord, mem_rd, mem_wr, ir_wr, pc_wr, pc_src, reg_wr, mem2reg, done, illegal
   function automatic logic [19:0] mk(logic [3:0] st, logic [2:0] op, logic src, logic iord,
                                      logic rd, logic wr, logic irw, logic pcw, logic [1:0] pcs,
                                      logic rw, logic [1:0] m2r, logic done, logic ill);
      return {st, op, src, iord, rd, wr, irw, pcw, pcs, rw, m2r, done, ill};
   endfunction

   // Queue one cycle of stimulus together with the outputs it must produce.
   task automatic drv(logic [6:0] op, logic rdy, logic tk, logic [19:0] e);
      stim.push_back({op, rdy, tk});
      sb.push_back(e);
   endtask

   function automatic logic [6:0] junk();
      return 7'($urandom);
   endfunction

   // Common per-cycle expectations
   function automatic logic [19:0] f_go();   return mk(0,0,0,0,1,0,1,1,0,0,0,0,0); endfunction
   function automatic logic [19:0] f_wait(); return mk(0,0,0,0,1,0,0,0,0,0,0,0,0); endfunction
   function automatic logic [19:0] dec();    return mk(1,0,0,0,0,0,0,0,0,0,0,0,0); endfunction

   task automatic test_reset();
      reset = 1'b0; opcode_i = 7'b0110011; mem_ready_i = 1'b1; branch_taken_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs() !== f_wait()) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=%h", obs(), f_wait());
      end
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic test_r_type();
      logic [8:0] s; logic [19:0] e; int n = 0;
      drv(junk(), 1, 0, f_go());
      drv(7'b0110011, 0, 1, dec());
      drv(junk(), 0, 1, mk(2,0,0,0,0,0,0,0,0,0,0,0,0));
      drv(junk(), 1, 1, mk(10,0,0,0,0,0,0,0,0,1,0,1,0));
      while (stim.size() > 0) begin
         s = stim.pop_front();
         {opcode_i, mem_ready_i, branch_taken_i} = s;
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            failures++;
            $display("FAIL r_type cyc%0d got=%h exp=%h", n, obs(), e);
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_i_lui();
      logic [8:0] s; logic [19:0] e; int n = 0;
      drv(junk(), 1, 0, f_go());
      drv(7'b0010011, 1, 0, dec());
      drv(junk(), 1, 0, mk(3,1,1,0,0,0,0,0,0,0,0,0,0));
      drv(junk(), 0, 0, mk(10,1,1,0,0,0,0,0,0,1,0,1,0));
      drv(junk(), 1, 0, f_go());
      drv(7'b0110111, 0, 0, dec());
      drv(junk(), 1, 0, mk(4,2,1,0,0,0,0,0,0,0,0,0,0));
      drv(junk(), 1, 0, mk(10,2,1,0,0,0,0,0,0,1,0,1,0));
      while (stim.size() > 0) begin
         s = stim.pop_front();
         {opcode_i, mem_ready_i, branch_taken_i} = s;
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            failures++;
            $display("FAIL i_lui cyc%0d got=%h exp=%h", n, obs(), e);
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load();
      logic [8:0] s; logic [19:0] e; int n = 0;
      drv(junk(), 0, 0, f_wait());
      drv(junk(), 1, 0, f_go());
      drv(7'b0000011, 1, 0, dec());
      drv(junk(), 1, 0, mk(7,5,1,0,0,0,0,0,0,0,0,0,0));
      drv(junk(), 0, 1, mk(8,5,1,1,1,0,0,0,0,0,0,0,0));
      drv(junk(), 0, 1, mk(8,5,1,1,1,0,0,0,0,0,0,0,0));
      drv(junk(), 1, 1, mk(8,5,1,1,1,0,0,0,0,0,0,0,0));
      drv(junk(), 0, 0, mk(11,5,0,0,0,0,0,0,0,1,1,1,0));
      while (stim.size() > 0) begin
         s = stim.pop_front();
         {opcode_i, mem_ready_i, branch_taken_i} = s;
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            failures++;
            $display("FAIL load cyc%0d got=%h exp=%h", n, obs(), e);
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_store();
      logic [8:0] s; logic [19:0] e; int n = 0;
      drv(junk(), 1, 0, f_go());
      drv(7'b0100011, 1, 0, dec());
      drv(junk(), 1, 0, mk(7,4,1,0,0,0,0,0,0,0,0,0,0));
      drv(junk(), 0, 0, mk(9,4,1,1,0,1,0,0,0,0,0,0,0));
      drv(junk(), 1, 0, mk(9,4,1,1,0,1,0,0,0,0,0,1,0));
      while (stim.size() > 0) begin
         s = stim.pop_front();
         {opcode_i, mem_ready_i, branch_taken_i} = s;
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            failures++;
            $display("FAIL store cyc%0d got=%h exp=%h", n, obs(), e);
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      logic [8:0] s; logic [19:0] e; int n = 0;
      drv(junk(), 1, 0, f_go());
      drv(7'b1100011, 1, 0, dec());
      drv(junk(), 0, 1, mk(5,3,0,0,0,0,0,1,1,0,0,1,0));
      drv(junk(), 1, 1, f_go());
      drv(7'b1100011, 1, 1, dec());
      drv(junk(), 1, 0, mk(5,3,0,0,0,0,0,0,1,0,0,1,0));
      while (stim.size() > 0) begin
         s = stim.pop_front();
         {opcode_i, mem_ready_i, branch_taken_i} = s;
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            failures++;
            $display("FAIL branch cyc%0d got=%h exp=%h", n, obs(), e);
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_jal();
      logic [8:0] s; logic [19:0] e; int n = 0;
      drv(junk(), 1, 0, f_go());
      drv(7'b1101111, 1, 0, dec());
      drv(junk(), 0, 0, mk(6,7,0,0,0,0,0,1,2,1,2,1,0));
      while (stim.size() > 0) begin
         s = stim.pop_front();
         {opcode_i, mem_ready_i, branch_taken_i} = s;
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            failures++;
            $display("FAIL jal cyc%0d got=%h exp=%h", n, obs(), e);
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_trap();
      logic [8:0] s; logic [19:0] e; int n = 0;
      drv(junk(), 1, 0, f_go());
      drv(7'b1111111, 1, 0, dec());
      for (int i = 0; i < 12; i++)
         drv(7'b0110011, 1'($urandom), 1'($urandom), mk(12,0,0,0,0,0,0,0,0,0,0,0,1));
      while (stim.size() > 0) begin
         s = stim.pop_front();
         {opcode_i, mem_ready_i, branch_taken_i} = s;
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            failures++;
            $display("FAIL trap cyc%0d got=%h exp=%h", n, obs(), e);
         end
         n++;
         @(posedge clk); #1;
      end
      reset = 1'b0;
      #1;
      checks++;
      if (obs() !== f_wait()) begin
         failures++;
         $display("FAIL trap_reset got=%h exp=%h", obs(), f_wait());
      end
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic test_reset_mid_store();
      logic [8:0] s; logic [19:0] e; int n = 0;
      drv(junk(), 1, 0, f_go());
      drv(7'b0100011, 1, 0, dec());
      drv(junk(), 1, 0, mk(7,4,1,0,0,0,0,0,0,0,0,0,0));
      drv(junk(), 0, 0, mk(9,4,1,1,0,1,0,0,0,0,0,0,0));
      while (stim.size() > 0) begin
         s = stim.pop_front();
         {opcode_i, mem_ready_i, branch_taken_i} = s;
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            failures++;
            $display("FAIL rst_mid cyc%0d got=%h exp=%h", n, obs(), e);
         end
         n++;
         @(posedge clk); #1;
      end
      // Still waiting in MEM_WR; pull reset in the middle of the cycle.
      mem_ready_i = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({Mem_Write_o, state_o, Mem_Read_o, Reg_Write_o, instr_done_o} !== {1'b0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL rst_mid_async wr=%b st=%0d rd=%b rw=%b done=%b required wr=0 st=0 rd=1 rw=0 done=0",
                  Mem_Write_o, state_o, Mem_Read_o, Reg_Write_o, instr_done_o);
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      mem_ready_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (obs() !== f_wait()) begin
            failures++;
            $display("FAIL rst_mid_fetch_wait cyc%0d got=%h exp=%h", i, obs(), f_wait());
         end
         @(posedge clk); #1;
      end
      mem_ready_i = 1'b1;
      @(negedge clk);
      checks++;
      if (obs() !== f_go()) begin
         failures++;
         $display("FAIL rst_mid_fetch_go got=%h exp=%h", obs(), f_go());
      end
      @(posedge clk); #1;
      checks++;
      if (state_o !== 4'd1) begin
         failures++;
         $display("FAIL rst_mid_decode got=%0d exp=1", state_o);
      end
   endtask

   initial begin
      test_reset();
      test_r_type();
      test_i_lui();
      test_load();
      test_store();
      test_branch();
      test_jal();
      test_trap();
      test_reset_mid_store();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
